// File: rtl/apv_pkg.sv
// ============================================================================
// Module      : apv_pkg
// Description : Shared state encoding and frame-format constants for the
//               APV25 frame decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apv_pkg;

  localparam int N_CH      = 128;
  localparam int ADDR_BITS = 8;
  localparam int HDR_LEN   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_ERRB = 2'd2,
    ST_DATA = 2'd3
  } apv_state_e;

endpackage : apv_pkg

`default_nettype wire

// File: rtl/apv_hdr_detect.sv
// ============================================================================
// Module      : apv_hdr_detect
// Description : Digital-level slicer and consecutive-high counter; pulses
//               found_o on the HDR_LEN-th consecutive high while searching.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apv_hdr_detect
  import apv_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              search_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic [DATA_W-1:0] threshold_i,
  output logic              bit_o,
  output logic              found_o
);

  localparam int CW = $clog2(HDR_LEN + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_o   = (sample_i >= threshold_i);
  assign found_o = search_i && bit_o && (cnt_q == CW'(HDR_LEN - 1));

  // A low sample, a completed header or leaving the search all restart the run.
  always_comb begin
    cnt_d = cnt_q;
    if (!search_i || !bit_o || found_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : apv_hdr_detect

`default_nettype wire

// File: rtl/apv_frame_decoder.sv
// ============================================================================
// Module      : apv_frame_decoder
// Description : Decodes APV25 frames (header, pipeline address, error bit,
//               N_CH analog samples) from a FIR-filtered sample stream.
//               Define APV_FRAME_CNT_EN to add the FRAME_COUNT output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apv_frame_decoder #(
  parameter int DATA_W    = 12,
  parameter int N_CH      = apv_pkg::N_CH,
  parameter int ADDR_BITS = apv_pkg::ADDR_BITS
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic [DATA_W-1:0]    DATA_IN,
  input  logic [DATA_W-1:0]    THRESHOLD,
  output logic [DATA_W-1:0]    DATA_OUT,
  output logic [6:0]           CH_OUT,
  output logic                 DATA_VALID,
  output logic [ADDR_BITS-1:0] APV_ADDR,
  output logic                 ADDR_VALID,
  output logic                 FRAME_START,
  output logic                 FRAME_END,
  output logic                 FRAME_ERR
`ifdef APV_FRAME_CNT_EN
  ,
  output logic [15:0]          FRAME_COUNT
`endif
);

  import apv_pkg::*;

  localparam int BIT_CW = $clog2(ADDR_BITS);

  apv_state_e           state_q, state_d;
  logic [BIT_CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]           ch_q, ch_d;
  logic [ADDR_BITS-1:0] shift_q, shift_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]    dout_q, dout_d;
  logic [6:0]           chout_q, chout_d;
  logic                 dvalid_q, dvalid_d;
  logic                 avalid_q, avalid_d;
  logic                 fstart_q, fstart_d;
  logic                 fend_q, fend_d;
  logic                 ferr_q, ferr_d;

  logic w_bit;
  logic w_found;

  apv_hdr_detect #(
    .DATA_W (DATA_W)
  ) u_hdr_detect (
    .clk_i       (CLK),
    .rst_i       (RST),
    .search_i    (ENABLE && (state_q == ST_IDLE)),
    .sample_i    (DATA_IN),
    .threshold_i (THRESHOLD),
    .bit_o       (w_bit),
    .found_o     (w_found)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ch_d      = ch_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    chout_d   = chout_q;
    dvalid_d  = 1'b0;
    avalid_d  = 1'b0;
    fstart_d  = 1'b0;
    fend_d    = 1'b0;
    ferr_d    = 1'b0;

    if (!ENABLE) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      ch_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_found) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
          end
        end
        ST_ADDR: begin
          shift_d = {shift_q[ADDR_BITS-2:0], w_bit};
          if (bit_cnt_q == BIT_CW'(ADDR_BITS - 1)) begin
            state_d   = ST_ERRB;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CW'(1);
          end
        end
        // Error bit is active-low; the frame is emitted regardless.
        ST_ERRB: begin
          addr_d   = shift_q;
          avalid_d = 1'b1;
          ferr_d   = !w_bit;
          ch_d     = '0;
          state_d  = ST_DATA;
        end
        ST_DATA: begin
          dvalid_d = 1'b1;
          dout_d   = DATA_IN;
          chout_d  = ch_q;
          fstart_d = (ch_q == 7'd0);
          if (ch_q == 7'(N_CH - 1)) begin
            fend_d  = 1'b1;
            ch_d    = '0;
            state_d = ST_IDLE;
          end else begin
            ch_d = ch_q + 7'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      ch_q      <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      chout_q   <= '0;
      dvalid_q  <= 1'b0;
      avalid_q  <= 1'b0;
      fstart_q  <= 1'b0;
      fend_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ch_q      <= ch_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      chout_q   <= chout_d;
      dvalid_q  <= dvalid_d;
      avalid_q  <= avalid_d;
      fstart_q  <= fstart_d;
      fend_q    <= fend_d;
      ferr_q    <= ferr_d;
    end
  end

  assign DATA_OUT    = dout_q;
  assign CH_OUT      = chout_q;
  assign DATA_VALID  = dvalid_q;
  assign APV_ADDR    = addr_q;
  assign ADDR_VALID  = avalid_q;
  assign FRAME_START = fstart_q;
  assign FRAME_END   = fend_q;
  assign FRAME_ERR   = ferr_q;

`ifdef APV_FRAME_CNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fcnt_q <= '0;
    end else if (fend_d) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign FRAME_COUNT = fcnt_q;
`endif

endmodule : apv_frame_decoder

`default_nettype wire

// File: tb/tb_apv_frame_decoder.sv
// ============================================================================
// Module      : tb_apv_frame_decoder
// Description : Self-checking bench for apv_frame_decoder (frame vectors with
//               expected outputs, scoreboard queue, reset/abort sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apv_frame_decoder;

  typedef struct {
    logic        en;
    logic [11:0] din;
    logic        dv;
    logic [11:0] dout;
    logic [6:0]  ch;
    logic        av;
    logic [7:0]  addr;
    logic        fs;
    logic        fe;
    logic        fer;
    logic [15:0] fc;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE = 1'b0;
  logic [11:0] DATA_IN = 12'd0;
  logic [11:0] THRESHOLD = 12'd2000;
  logic [11:0] DATA_OUT;
  logic [6:0]  CH_OUT;
  logic        DATA_VALID;
  logic [7:0]  APV_ADDR;
  logic        ADDR_VALID;
  logic        FRAME_START;
  logic        FRAME_END;
  logic        FRAME_ERR;
`ifdef APV_FRAME_CNT_EN
  logic [15:0] FRAME_COUNT;
`endif

  apv_frame_decoder #(
    .DATA_W    (12),
    .N_CH      (128),
    .ADDR_BITS (8)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ENABLE      (ENABLE),
    .DATA_IN     (DATA_IN),
    .THRESHOLD   (THRESHOLD),
    .DATA_OUT    (DATA_OUT),
    .CH_OUT      (CH_OUT),
    .DATA_VALID  (DATA_VALID),
    .APV_ADDR    (APV_ADDR),
    .ADDR_VALID  (ADDR_VALID),
    .FRAME_START (FRAME_START),
    .FRAME_END   (FRAME_END),
    .FRAME_ERR   (FRAME_ERR)
`ifdef APV_FRAME_CNT_EN
    ,
    .FRAME_COUNT (FRAME_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  vec_t       vecs[$];
  vec_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_addr = 8'h00;
  int         m_fc = 0;

  task automatic push_vec(input logic en, input int din, input logic dv, input int dout,
                          input int ch, input logic av, input logic fs, input logic fe,
                          input logic fer);
    vec_t v;
    v.en   = en;
    v.din  = 12'(din);
    v.dv   = dv;
    v.dout = 12'(dout);
    v.ch   = 7'(ch);
    v.av   = av;
    v.addr = m_addr;
    v.fs   = fs;
    v.fe   = fe;
    v.fer  = fer;
    v.fc   = 16'(m_fc);
    vecs.push_back(v);
  endtask

  task automatic add_idle(input int n, input int din);
    for (int i = 0; i < n; i++) push_vec(1'b1, din, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // n_drive channels are sent; abort then drops ENABLE for one sample.
  task automatic add_frame(input logic [7:0] addr, input logic errhi, input int base,
                           input int hi, input int n_drive, input logic abort);
    for (int i = 0; i < 3; i++) push_vec(1'b1, hi, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 7; i >= 0; i--) push_vec(1'b1, addr[i] ? hi : 500, 0, 0, 0, 0, 0, 0, 0);
    m_addr = addr;
    push_vec(1'b1, errhi ? hi : 500, 0, 0, 0, 1'b1, 0, 0, !errhi);
    for (int ch = 0; ch < n_drive; ch++) begin
      if (ch == 127) m_fc = (m_fc + 1) % 65536;
      push_vec(1'b1, base + ch, 1'b1, base + ch, ch, 0, ch == 0, ch == 127, 0);
    end
    if (abort) push_vec(1'b0, 3000, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_out(input vec_t e);
    logic bad;
    bad = (DATA_VALID !== e.dv) || (ADDR_VALID !== e.av) || (FRAME_START !== e.fs) ||
          (FRAME_END !== e.fe) || (FRAME_ERR !== e.fer) || (APV_ADDR !== e.addr);
    if (e.dv) bad = bad || (DATA_OUT !== e.dout) || (CH_OUT !== e.ch);
`ifdef APV_FRAME_CNT_EN
    bad = bad || (FRAME_COUNT !== e.fc);
`endif
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL cycle t=%0t: got dv=%b do=%0d ch=%0d av=%b addr=%h fs=%b fe=%b err=%b, want dv=%b do=%0d ch=%0d av=%b addr=%h fs=%b fe=%b err=%b fc=%0d",
               $time, DATA_VALID, DATA_OUT, CH_OUT, ADDR_VALID, APV_ADDR, FRAME_START,
               FRAME_END, FRAME_ERR, e.dv, e.dout, e.ch, e.av, e.addr, e.fs, e.fe, e.fer, e.fc);
    end
  endtask

  task automatic check_zero(input string name);
    logic bad;
    bad = (DATA_VALID !== 1'b0) || (ADDR_VALID !== 1'b0) || (FRAME_START !== 1'b0) ||
          (FRAME_END !== 1'b0) || (FRAME_ERR !== 1'b0) || (APV_ADDR !== 8'h00) ||
          (DATA_OUT !== 12'd0) || (CH_OUT !== 7'd0);
`ifdef APV_FRAME_CNT_EN
    bad = bad || (FRAME_COUNT !== 16'd0);
`endif
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: got dv=%b do=%0d ch=%0d av=%b addr=%h fs=%b fe=%b err=%b, want all zero",
               name, DATA_VALID, DATA_OUT, CH_OUT, ADDR_VALID, APV_ADDR, FRAME_START,
               FRAME_END, FRAME_ERR);
    end
  endtask

  task automatic run_vecs();
    vec_t v;
    for (int i = 0; i < vecs.size(); i++) begin
      v       = vecs[i];
      ENABLE  = v.en;
      DATA_IN = v.din;
      exp_q.push_back(v);
      @(posedge CLK);
      #1;
      check_out(exp_q.pop_front());
    end
    vecs.delete();
  endtask

  initial begin
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset_state");
    RST = 1'b0;

    add_idle(4, 0);
    add_frame(8'hA5, 1'b1, 100, 3000, 128, 1'b0);
    add_idle(3, 0);
    add_frame(8'hA5, 1'b0, 100, 3000, 128, 1'b0);
    add_idle(2, 0);
    for (int r = 0; r < 3; r++) begin
      push_vec(1'b1, 3000, 0, 0, 0, 0, 0, 0, 0);
      push_vec(1'b1, 500, 0, 0, 0, 0, 0, 0, 0);
      add_idle(33, 0);
      push_vec(1'b1, 3000, 0, 0, 0, 0, 0, 0, 0);
      push_vec(1'b1, 3000, 0, 0, 0, 0, 0, 0, 0);
      push_vec(1'b1, 500, 0, 0, 0, 0, 0, 0, 0);
      add_idle(32, 0);
    end
    add_frame(8'h96, 1'b1, 200, 2000, 128, 1'b0);
    add_idle(2, 0);
    add_frame(8'h5A, 1'b1, 100, 3000, 60, 1'b1);
    add_idle(3, 0);
    add_frame(8'hC3, 1'b1, 300, 3000, 128, 1'b0);
    add_idle(2, 0);
    run_vecs();

    RST = 1'b1;
    #1;
    check_zero("reset_pulse");
    @(posedge CLK);
    #1;
    RST    = 1'b0;
    m_addr = 8'h00;
    m_fc   = 0;

    add_frame(8'hA5, 1'b1, 100, 3000, 128, 1'b0);
    add_frame(8'h5A, 1'b0, 2500, 3000, 128, 1'b0);
    add_frame(8'h0F, 1'b1, 100, 3000, 11, 1'b0);
    run_vecs();

`ifdef APV_FRAME_CNT_EN
    checks++;
    if (FRAME_COUNT !== 16'd2) begin
      errors++;
      $display("FAIL frame_count_pre_rst: got %0d want 2", FRAME_COUNT);
    end
`endif

    RST = 1'b1;
    #1;
    check_zero("reset_async");
    ENABLE  = 1'b1;
    DATA_IN = 12'd3000;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check_zero("reset_hold");
    end
    RST    = 1'b0;
    m_addr = 8'h00;
    m_fc   = 0;

    add_idle(2, 0);
    add_frame(8'h3C, 1'b1, 100, 3000, 128, 1'b0);
    add_idle(2, 0);
    run_vecs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_apv_frame_decoder

`default_nettype wire
